// File: rtl/cic_pkg.sv
// Shared CIC definitions: default sizing, width derivation and the
// interpolator FSM state type. Also used by the comb and decimator blocks.
package cic_pkg;

  localparam int CIC_IW = 12;
  localparam int CIC_NS = 3;
  localparam int CIC_R  = 8;

  // Number of bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Accumulator width that holds the full CIC gain without loss.
  function automatic int cic_ow(input int iw, input int ns, input int r);
    return iw + ns * clog2(r);
  endfunction

  localparam int CIC_OW = cic_ow(CIC_IW, CIC_NS, CIC_R);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } cic_state_e;

endpackage

// File: rtl/cic_interp_integrator_if.sv
// Sample bus between the comb section and the interpolator integrator
// section. The master supplies low-rate samples; the slave returns the
// high-rate integrator output with its strobes.
interface cic_interp_integrator_if
  import cic_pkg::*;
#(
  parameter int IW = CIC_IW,
  parameter int OW = CIC_OW
) ();

  logic                 i_ce;
  logic signed [IW-1:0] i_data;
  logic signed [OW-1:0] o_data;
  logic                 o_ready;
  logic                 o_overrun;

  modport master (
    output i_ce,
    output i_data,
    input  o_data,
    input  o_ready,
    input  o_overrun
  );

  modport slave (
    input  i_ce,
    input  i_data,
    output o_data,
    output o_ready,
    output o_overrun
  );

endinterface

// File: rtl/cic_integrator.sv
// One integrator stage: an OW-bit wrapping accumulator that adds its input
// whenever the input is flagged valid, and passes that valid flag on one
// clock later so the next stage sees the updated sum together with its flag.
module cic_integrator #(
  parameter int OW = 21
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic signed [OW-1:0] i_data,
  output logic                 o_valid,
  output logic signed [OW-1:0] o_data
);

  // Accumulate on valid slots only; modular wrap is intended and is undone by the comb section.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data <= o_data + i_data;
      end
    end
  end

endmodule

// File: rtl/cic_interp_integrator.sv
// Integrator back end of the CIC interpolator. Each low-rate sample is
// zero-stuffed into a burst of R high-rate slots, pushed through NS
// cascaded integrators, and emitted as R strobed high-rate outputs.
module cic_interp_integrator
  import cic_pkg::*;
#(
  parameter int IW = CIC_IW,
  parameter int NS = CIC_NS,
  parameter int R  = CIC_R
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  cic_interp_integrator_if.slave bus
);

  localparam int OW = cic_ow(IW, NS, R);
  localparam int PW = clog2(R);
  localparam logic [PW-1:0] LAST_PHASE  = PW'(R - 1);
  localparam logic [PW-1:0] FIRST_PHASE = PW'(1);

  cic_state_e           state_q;
  cic_state_e           state_d;
  logic [PW-1:0]        phase_q;
  logic [PW-1:0]        phase_d;
  logic signed [OW-1:0] x_q;
  logic signed [OW-1:0] x_d;
  logic                 v0_q;
  logic                 v0_d;
  logic                 overrun_d;
  logic signed [OW-1:0] sext_data;
  logic signed [OW-1:0] s [NS+1];
  logic                 v [NS+1];

  assign sext_data = {{(OW - IW){bus.i_data[IW-1]}}, bus.i_data};

  // Burst sequencing: decide what the inject register loads this clock and where the phase goes next.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    x_d       = '0;
    v0_d      = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_ce) begin
          x_d     = sext_data;
          v0_d    = 1'b1;
          phase_d = FIRST_PHASE;
          state_d = BURST;
        end
      end
      BURST: begin
        v0_d = 1'b1;
        if (bus.i_ce) begin
          x_d       = sext_data;
          phase_d   = FIRST_PHASE;
          overrun_d = (phase_q != LAST_PHASE);
        end else if (phase_q == LAST_PHASE) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + FIRST_PHASE;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // FSM state, phase counter and the zero-stuffed inject register with its valid flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      x_q     <= '0;
      v0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      v0_q    <= v0_d;
    end
  end

  assign s[0] = x_q;
  assign v[0] = v0_q;

  for (genvar k = 1; k <= NS; k++) begin : g_stage
    cic_integrator #(
      .OW(OW)
    ) u_integrator (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (v[k-1]),
      .i_data  (s[k-1]),
      .o_valid (v[k]),
      .o_data  (s[k])
    );
  end

  // Register the last integrator and its valid flag as the high-rate output; overrun is a one-clock pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      bus.o_data    <= '0;
      bus.o_ready   <= 1'b0;
      bus.o_overrun <= 1'b0;
    end else begin
      bus.o_data    <= s[NS];
      bus.o_ready   <= v[NS];
      bus.o_overrun <= overrun_d;
    end
  end

endmodule
